// File: rtl/uart_boot_loader.sv
// UART boot loader: streams a length-prefixed program image from UART into RAM,
// returns a checksum byte, then hands the RAM port and reset release to the core.
module uart_boot_loader #(
    parameter int         ADDR_WIDTH = 12,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  load_req,
    input  logic [7:0]            rxdata,
    input  logic                  rxready,
    output logic [7:0]            txdata,
    output logic                  txstart,
    input  logic                  txready,
    input  logic [15:0]           cpu_addr,
    input  logic [7:0]            cpu_dout,
    input  logic                  cpu_wr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_din,
    output logic                  ram_we,
    output logic                  cpu_nrst,
    output logic                  busy,
    output logic                  error
);

    localparam logic [2:0] S_CHECK    = 3'd0;
    localparam logic [2:0] S_SYNC     = 3'd1;
    localparam logic [2:0] S_LEN_HI   = 3'd2;
    localparam logic [2:0] S_LEN_LO   = 3'd3;
    localparam logic [2:0] S_DATA     = 3'd4;
    localparam logic [2:0] S_SEND_SUM = 3'd5;
    localparam logic [2:0] S_RUN      = 3'd6;
    localparam logic [2:0] S_ERR      = 3'd7;

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

    logic [2:0]            state;
    logic [15:0]           len;
    logic [15:0]           ptr;
    logic [7:0]            sum;
    logic [ADDR_WIDTH-1:0] wr_addr_p1;
    logic [7:0]            wr_din_p1;
    logic                  wr_we_p1;

    logic [15:0] len_full;
    logic [15:0] ptr_next;
    logic        unused_cpu_addr_hi;

    assign len_full           = {len[15:8], rxdata};
    assign ptr_next           = ptr + 16'd1;
    assign unused_cpu_addr_hi = ^cpu_addr[15:ADDR_WIDTH];

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_CHECK;
            len        <= '0;
            ptr        <= '0;
            sum        <= '0;
            wr_addr_p1 <= '0;
            wr_din_p1  <= '0;
            wr_we_p1   <= 1'b0;
            txdata     <= '0;
            txstart    <= 1'b0;
            cpu_nrst   <= 1'b0;
            error      <= 1'b0;
        end else begin
            wr_we_p1 <= 1'b0;
            txstart  <= 1'b0;
            // Core reset is released one cycle after RUN is entered.
            cpu_nrst <= (state == S_RUN);
            case (state)
                S_CHECK: state <= load_req ? S_SYNC : S_RUN;
                S_SYNC: begin
                    if (rxready && rxdata == SYNC_BYTE) state <= S_LEN_HI;
                end
                S_LEN_HI: begin
                    if (rxready) begin
                        len[15:8] <= rxdata;
                        state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (rxready) begin
                        len[7:0] <= rxdata;
                        ptr      <= '0;
                        sum      <= '0;
                        if (len_full == 16'd0) begin
                            state <= S_SEND_SUM;
                        end else if ({1'b0, len_full} > CAPACITY) begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                // Received byte becomes a RAM write one cycle later.
                S_DATA: begin
                    if (rxready) begin
                        wr_addr_p1 <= ptr[ADDR_WIDTH-1:0];
                        wr_din_p1  <= rxdata;
                        wr_we_p1   <= 1'b1;
                        ptr        <= ptr_next;
                        sum        <= csum_add(sum, rxdata);
                        if (ptr_next == len) state <= S_SEND_SUM;
                    end
                end
                S_SEND_SUM: begin
                    if (txready) begin
                        txdata  <= sum;
                        txstart <= 1'b1;
                        state   <= S_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // The core only reaches the RAM once the loader has finished.
    assign ram_addr = (state == S_RUN) ? cpu_addr[ADDR_WIDTH-1:0] : wr_addr_p1;
    assign ram_din  = (state == S_RUN) ? cpu_dout : wr_din_p1;
    assign ram_we   = (state == S_RUN) ? cpu_wr : wr_we_p1;
    assign busy     = (state != S_RUN) && (state != S_ERR);

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sits between the UART receiver/transmitter, the z23 core and the 4096x8 program RAM.
- At boot it can take over the RAM write port and stream a program image received over UART into RAM starting at address 0.
- After the load it returns a checksum byte over UART and releases the core from reset.
- Outside loading it is a transparent pass-through of the core's memory bus to the RAM.

Parameters:
- ADDR_WIDTH, 12, RAM address width; capacity is 2^ADDR_WIDTH bytes.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous active-low reset
- load_req  input  1  sampled once after reset; 1 = enter load mode
- rxdata  input  8  received UART byte
- rxready  input  1  one-cycle strobe; rxdata valid
- txdata  output  8  byte to transmit
- txstart  output  1  one-cycle strobe launching txdata
- txready  input  1  transmitter idle, may accept byte
- cpu_addr  input  16  core memory address
- cpu_dout  input  8  core write data
- cpu_wr  input  1  core write enable
- ram_addr  output  ADDR_WIDTH  RAM address
- ram_din  output  8  RAM write data
- ram_we  output  1  RAM write enable
- cpu_nrst  output  1  active-low reset to core
- busy  output  1  high in any state except RUN and ERR
- error  output  1  frame length exceeded capacity

Behaviour:
- Reset values: state=CHECK, cpu_nrst=0, txstart=0, txdata=0, ram_we=0, ram_addr=0, ram_din=0, error=0, sum=0, ptr=0, len=0.
- CHECK: one cycle. Go to SYNC if load_req=1, else go to RUN.
- SYNC: on rxready with rxdata==SYNC_BYTE go to LEN_HI; other bytes are discarded.
- LEN_HI: on rxready, len[15:8]=rxdata, go to LEN_LO.
- LEN_LO: on rxready, len[7:0]=rxdata. Then:
  - len==0: go to SEND_SUM.
  - len > 2^ADDR_WIDTH: go to ERR.
  - otherwise: go to DATA with ptr=0, sum=0.
- DATA: on each rxready:
  - Next cycle ram_addr=ptr, ram_din=rxdata, ram_we=1 for exactly one cycle (1-cycle registered latency).
  - ptr+=1; sum=(sum+rxdata) mod 256.
  - After the byte where ptr+1==len, go to SEND_SUM.
  - ram_we is 0 in cycles with no strobe.
- SEND_SUM: wait for txready=1. In that cycle register txdata=sum and pulse txstart=1 for one cycle, then go to RUN. txstart never asserts while txready=0.
- RUN:
  - cpu_nrst=1 (registered; rises the cycle after entry).
  - ram_addr=cpu_addr[ADDR_WIDTH-1:0], ram_din=cpu_dout, ram_we=cpu_wr, combinational pass-through.
  - rxready is ignored.
  - RUN is left only by reset.
- ERR: error=1, cpu_nrst=0, ram_we=0, all rx ignored until reset.
- Bus ownership:
  - In every state other than RUN the loader owns the RAM port and core writes are blocked.
  - cpu_nrst stays 0 throughout loading, so the core issues nothing.
- Boundaries:
  - len==2^ADDR_WIDTH is legal; the last write goes to address 2^ADDR_WIDTH-1 and ptr never wraps within a frame.
  - An rxready arriving in the same cycle as the final registered write is handled normally (no lost byte).
  - Reset mid-load: state, outputs and cpu_nrst return to reset values immediately. Previously written RAM bytes remain; no RAM clear is performed.
  - Back-to-back rxready on consecutive cycles is supported at full rate in all states.

Test Plan:
- load_req=1; rx A5,00,03,11,22,33 -> ram_we pulses with (addr,din)=(0,11),(1,22),(2,33), each one cycle after its strobe; txready=1 -> txdata=66 with one txstart pulse; cpu_nrst rises next cycle; busy falls.
- load_req=1; rx 00,FF,A5,00,01,7E -> leading 00,FF ignored; single write (0,7E); checksum 7E.
- load_req=1; rx A5,00,00 -> no ram_we; txdata=00 sent; enters RUN.
- load_req=1; rx A5,10,01 (len=4097) -> error=1, cpu_nrst stays 0, later bytes cause no writes; nrst pulse clears error.
- load_req=0 -> RUN two cycles after reset release; cpu_addr=0x1ABC, cpu_dout=5A, cpu_wr=1 -> ram_addr=ABC, ram_din=5A, ram_we=1 the same cycle.
- Reset mid-DATA after 2 of 5 bytes -> cpu_nrst=0 and ram_we=0 immediately; a new frame A5,00,01,99 loads cleanly with checksum 99; hold txready=0 for 10 cycles before SEND_SUM completes -> no txstart until txready=1.
